// File: rtl/tx_link_seq.sv
// Transmit link sequencer: code-group sync, multiframe-aligned ILA start, then user data,
// with SYNC_n decoding into error reports (short low runs) and resync requests (long runs).
module tx_link_seq #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST_n,
   input  logic       EN,
   input  logic [2:0] SUBCLASSV,
   input  logic       LMFC_SYNCED,
   input  logic [3:0] LMFC_ME,
   input  logic [7:0] ILA_DELAY,
   input  logic       ILA_DONE,
   input  logic [7:0] RESYNC_TH,
   input  logic       CLR_CNT,
   input  logic       SYNC_n,
   output logic [2:0] STATE,
   output logic       CGS_EN,
   output logic       ILA_START,
   output logic       DATA_EN,
   output logic       ERR_PULSE,
   output logic [7:0] ERR_CNT,
   output logic [7:0] RESYNC_CNT
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CGS     = 3'd1;
   localparam logic [2:0] ST_WAIT_MF = 3'd2;
   localparam logic [2:0] ST_DELAY   = 3'd3;
   localparam logic [2:0] ST_ILA     = 3'd4;
   localparam logic [2:0] ST_DATA    = 3'd5;

   logic       sync_reg [SYNC_STAGES];
   logic       sync_s;
   logic [2:0] state_reg, state_next;
   logic [7:0] dly_reg, dly_next;
   logic [7:0] run_reg, run_next;
   logic       ila_start_reg, ila_start_next;
   logic       err_pulse_reg, err_pulse_next;
   logic [7:0] err_cnt_reg, resync_cnt_reg;
   logic [2:0] subclass_reg;
   logic [7:0] ila_dly_reg;
   logic       err_inc, resync_inc, cfg_load, me_any;
   logic [7:0] run_inc, th_eff;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge CLK or negedge RST_n) begin
               if (!RST_n) sync_reg[gi] <= 1'b0;
               else        sync_reg[gi] <= SYNC_n;
            end
         end else begin : g_next
            always_ff @(posedge CLK or negedge RST_n) begin
               if (!RST_n) sync_reg[gi] <= 1'b0;
               else        sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign sync_s = sync_reg[SYNC_STAGES-1];
   assign me_any = |LMFC_ME;

   always_comb begin
      state_next     = state_reg;
      dly_next       = dly_reg;
      run_next       = run_reg;
      ila_start_next = 1'b0;
      err_pulse_next = 1'b0;
      err_inc        = 1'b0;
      resync_inc     = 1'b0;
      run_inc        = (run_reg == 8'hFF) ? run_reg : run_reg + 8'd1;
      // A zero threshold behaves as one: every low cycle in DATA is a resync.
      th_eff         = (RESYNC_TH == 8'd0) ? 8'd1 : RESYNC_TH;
      if (!EN) begin
         state_next = ST_IDLE;
         dly_next   = 8'd0;
         run_next   = 8'd0;
      end else begin
         case (state_reg)
            ST_IDLE: state_next = ST_CGS;
            ST_CGS: begin
               if (sync_s && (subclass_reg == 3'd0 || LMFC_SYNCED))
                  state_next = ST_WAIT_MF;
            end
            ST_WAIT_MF: begin
               if (!sync_s) begin
                  state_next = ST_CGS;
               end else if (me_any) begin
                  if (ila_dly_reg == 8'd0) begin
                     state_next     = ST_ILA;
                     ila_start_next = 1'b1;
                  end else begin
                     dly_next   = ila_dly_reg - 8'd1;
                     state_next = ST_DELAY;
                  end
               end
            end
            ST_DELAY: begin
               if (!sync_s) begin
                  state_next = ST_CGS;
                  dly_next   = 8'd0;
               end else if (me_any) begin
                  if (dly_reg == 8'd0) begin
                     state_next     = ST_ILA;
                     ila_start_next = 1'b1;
                  end else begin
                     dly_next = dly_reg - 8'd1;
                  end
               end
            end
            ST_ILA: begin
               if (!sync_s)       state_next = ST_CGS;
               else if (ILA_DONE) state_next = ST_DATA;
            end
            ST_DATA: begin
               if (!sync_s) begin
                  if (run_inc >= th_eff) begin
                     state_next = ST_CGS;
                     resync_inc = 1'b1;
                     run_next   = 8'd0;
                  end else begin
                     run_next = run_inc;
                  end
               end else begin
                  // A low run that ended short of the threshold is an error report.
                  if (run_reg != 8'd0) begin
                     err_pulse_next = 1'b1;
                     err_inc        = 1'b1;
                  end
                  run_next = 8'd0;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
      cfg_load = (state_next == ST_CGS) && (state_reg != ST_CGS);
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_reg      <= ST_IDLE;
         dly_reg        <= 8'd0;
         run_reg        <= 8'd0;
         ila_start_reg  <= 1'b0;
         err_pulse_reg  <= 1'b0;
         err_cnt_reg    <= 8'd0;
         resync_cnt_reg <= 8'd0;
         subclass_reg   <= 3'd0;
         ila_dly_reg    <= 8'd0;
      end else begin
         state_reg     <= state_next;
         dly_reg       <= dly_next;
         run_reg       <= run_next;
         ila_start_reg <= ila_start_next;
         err_pulse_reg <= err_pulse_next;
         // Link configuration is sampled only when (re)entering CGS.
         if (cfg_load) begin
            subclass_reg <= SUBCLASSV;
            ila_dly_reg  <= ILA_DELAY;
         end
         if (CLR_CNT)                              err_cnt_reg <= 8'd0;
         else if (err_inc && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
         if (CLR_CNT)                                       resync_cnt_reg <= 8'd0;
         else if (resync_inc && resync_cnt_reg != 8'hFF) resync_cnt_reg <= resync_cnt_reg + 8'd1;
      end
   end

   assign STATE      = state_reg;
   assign CGS_EN     = (state_reg == ST_CGS) || (state_reg == ST_WAIT_MF) || (state_reg == ST_DELAY);
   assign DATA_EN    = (state_reg == ST_DATA);
   assign ILA_START  = ila_start_reg;
   assign ERR_PULSE  = err_pulse_reg;
   assign ERR_CNT    = err_cnt_reg;
   assign RESYNC_CNT = resync_cnt_reg;

endmodule

// File: tb/tb_tx_link_seq.sv
// Directed self-checking bench for tx_link_seq; each task drives one scenario and checks inline.
module tb_tx_link_seq;

   logic       CLK = 1'b0;
   logic       RST_n, EN, LMFC_SYNCED, ILA_DONE, CLR_CNT, SYNC_n;
   logic [2:0] SUBCLASSV;
   logic [3:0] LMFC_ME;
   logic [7:0] ILA_DELAY, RESYNC_TH;
   logic [2:0] STATE;
   logic       CGS_EN, ILA_START, DATA_EN, ERR_PULSE;
   logic [7:0] ERR_CNT, RESYNC_CNT;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   tx_link_seq #(.SYNC_STAGES(2)) dut (
      .CLK(CLK), .RST_n(RST_n), .EN(EN), .SUBCLASSV(SUBCLASSV), .LMFC_SYNCED(LMFC_SYNCED),
      .LMFC_ME(LMFC_ME), .ILA_DELAY(ILA_DELAY), .ILA_DONE(ILA_DONE), .RESYNC_TH(RESYNC_TH),
      .CLR_CNT(CLR_CNT), .SYNC_n(SYNC_n), .STATE(STATE), .CGS_EN(CGS_EN), .ILA_START(ILA_START),
      .DATA_EN(DATA_EN), .ERR_PULSE(ERR_PULSE), .ERR_CNT(ERR_CNT), .RESYNC_CNT(RESYNC_CNT)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Walk the link into DATA with subclass 0 and zero ILA delay.
   task automatic goto_data();
      SYNC_n = 1'b1; EN = 1'b0; SUBCLASSV = 3'd0; ILA_DELAY = 8'd0;
      tick(3);
      EN = 1'b1;
      tick(2);
      LMFC_ME = 4'b0001;
      tick();
      LMFC_ME = 4'b0000; ILA_DONE = 1'b1;
      tick();
      ILA_DONE = 1'b0;
   endtask

   task automatic test_reset();
      tick(3);
      n_checks++;
      if (STATE !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", STATE); end
      n_checks++;
      if ({CGS_EN, ILA_START, DATA_EN, ERR_PULSE} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_strobes: got %b want 0000", {CGS_EN, ILA_START, DATA_EN, ERR_PULSE});
      end
      n_checks++;
      if ({ERR_CNT, RESYNC_CNT} !== 16'h0000) begin
         n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", ERR_CNT, RESYNC_CNT);
      end
      RST_n = 1'b1;
      tick(2);
      n_checks++;
      if (STATE !== 3'd0) begin n_fail++; $display("FAIL idle_en0: got %0d want 0", STATE); end
      $display("test_reset: done");
   endtask

   task automatic test_subclass0();
      int pulses = 0;
      int at = -1;
      logic [2:0] st7 = '0, st22 = '0;
      SUBCLASSV = 3'd0; ILA_DELAY = 8'd2; SYNC_n = 1'b0; EN = 1'b1;
      tick();
      n_checks++;
      if (STATE !== 3'd1 || CGS_EN !== 1'b1) begin
         n_fail++; $display("FAIL sc0_cgs: state %0d cgs_en %b want 1/1", STATE, CGS_EN);
      end
      SYNC_n = 1'b1;
      tick(2);
      n_checks++;
      if (STATE !== 3'd1) begin n_fail++; $display("FAIL sc0_sync_latency: got %0d want 1", STATE); end
      tick();
      n_checks++;
      if (STATE !== 3'd2 || CGS_EN !== 1'b1) begin
         n_fail++; $display("FAIL sc0_wait_mf: state %0d cgs_en %b want 2/1", STATE, CGS_EN);
      end
      for (int i = 0; i < 28; i++) begin
         LMFC_ME = (i % 8 == 7) ? 4'b0100 : 4'b0000;
         tick();
         if (ILA_START === 1'b1) begin pulses++; if (at < 0) at = i; end
         if (i == 7)  st7  = STATE;
         if (i == 22) st22 = STATE;
      end
      LMFC_ME = 4'b0000;
      n_checks++;
      if (st7 !== 3'd3) begin n_fail++; $display("FAIL sc0_delay_entry: got %0d want 3", st7); end
      n_checks++;
      if (st22 !== 3'd3) begin n_fail++; $display("FAIL sc0_delay_hold: got %0d want 3", st22); end
      n_checks++;
      if (pulses != 1 || at != 23) begin
         n_fail++; $display("FAIL sc0_ila_start: %0d pulses at cycle %0d want 1 at 23", pulses, at);
      end
      n_checks++;
      if (STATE !== 3'd4 || CGS_EN !== 1'b0 || DATA_EN !== 1'b0) begin
         n_fail++; $display("FAIL sc0_ila: state %0d cgs %b data %b want 4/0/0", STATE, CGS_EN, DATA_EN);
      end
      ILA_DONE = 1'b1;
      tick();
      ILA_DONE = 1'b0;
      n_checks++;
      if (STATE !== 3'd5 || DATA_EN !== 1'b1) begin
         n_fail++; $display("FAIL sc0_data: state %0d data_en %b want 5/1", STATE, DATA_EN);
      end
      $display("test_subclass0: ila_start pulses=%0d at cycle %0d", pulses, at);
   endtask

   task automatic test_error_report();
      int pulses = 0;
      int at = -1;
      int bad = 0;
      RESYNC_TH = 8'd20;
      for (int i = 0; i < 12; i++) begin
         SYNC_n = (i < 4) ? 1'b0 : 1'b1;
         tick();
         if (ERR_PULSE === 1'b1) begin pulses++; if (at < 0) at = i; end
         if (STATE !== 3'd5) bad++;
      end
      n_checks++;
      if (pulses != 1 || at != 6) begin
         n_fail++; $display("FAIL err_pulse: %0d pulses at cycle %0d want 1 at 6", pulses, at);
      end
      n_checks++;
      if (ERR_CNT !== 8'd1) begin n_fail++; $display("FAIL err_cnt: got %0d want 1", ERR_CNT); end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL err_stay_data: %0d cycles outside DATA want 0", bad); end
      $display("test_error_report: err_cnt=%0d", ERR_CNT);
   endtask

   task automatic test_resync();
      int pulses = 0;
      int at = -1;
      for (int i = 0; i < 40; i++) begin
         SYNC_n = (i < 25) ? 1'b0 : 1'b1;
         tick();
         if (ERR_PULSE === 1'b1) pulses++;
         if (STATE === 3'd1 && at < 0) at = i;
      end
      n_checks++;
      if (at != 21) begin n_fail++; $display("FAIL resync_cgs: CGS at cycle %0d want 21", at); end
      n_checks++;
      if (RESYNC_CNT !== 8'd1 || ERR_CNT !== 8'd1) begin
         n_fail++; $display("FAIL resync_counts: resync %0d err %0d want 1/1", RESYNC_CNT, ERR_CNT);
      end
      n_checks++;
      if (pulses != 0) begin n_fail++; $display("FAIL resync_no_err: %0d pulses want 0", pulses); end
      $display("test_resync: resync_cnt=%0d", RESYNC_CNT);
   endtask

   task automatic test_ila_delay0();
      int pulses = 0;
      int at = -1;
      SYNC_n = 1'b1; EN = 1'b0;
      tick(3);
      n_checks++;
      if (STATE !== 3'd0) begin n_fail++; $display("FAIL en0_idle: got %0d want 0", STATE); end
      ILA_DELAY = 8'd0; EN = 1'b1;
      tick(2);
      n_checks++;
      if (STATE !== 3'd2) begin n_fail++; $display("FAIL d0_wait_mf: got %0d want 2", STATE); end
      for (int i = 0; i < 10; i++) begin
         LMFC_ME = (i == 5) ? 4'b1000 : 4'b0000;
         tick();
         if (ILA_START === 1'b1) begin pulses++; if (at < 0) at = i; end
      end
      n_checks++;
      if (pulses != 1 || at != 5 || STATE !== 3'd4) begin
         n_fail++; $display("FAIL d0_ila_start: %0d pulses at %0d state %0d want 1 at 5 state 4", pulses, at, STATE);
      end
      ILA_DONE = 1'b1;
      tick();
      ILA_DONE = 1'b0;
      $display("test_ila_delay0: ila_start at cycle %0d", at);
   endtask

   task automatic test_resync_th0();
      int pulses = 0;
      int at = -1;
      RESYNC_TH = 8'd0;
      for (int i = 0; i < 8; i++) begin
         SYNC_n = (i == 0) ? 1'b0 : 1'b1;
         tick();
         if (ERR_PULSE === 1'b1) pulses++;
         if (STATE === 3'd1 && at < 0) at = i;
      end
      RESYNC_TH = 8'd20;
      n_checks++;
      if (at != 2 || RESYNC_CNT !== 8'd2) begin
         n_fail++; $display("FAIL th0_resync: CGS at %0d resync %0d want 2/2", at, RESYNC_CNT);
      end
      n_checks++;
      if (pulses != 0 || ERR_CNT !== 8'd1) begin
         n_fail++; $display("FAIL th0_no_err: pulses %0d err %0d want 0/1", pulses, ERR_CNT);
      end
      $display("test_resync_th0: resync_cnt=%0d", RESYNC_CNT);
   endtask

   task automatic test_err_saturate();
      int pulses = 0;
      int bad = 0;
      goto_data();
      CLR_CNT = 1'b1;
      tick();
      CLR_CNT = 1'b0;
      n_checks++;
      if (ERR_CNT !== 8'd0 || RESYNC_CNT !== 8'd0) begin
         n_fail++; $display("FAIL clr_cnt: err %0d resync %0d want 0/0", ERR_CNT, RESYNC_CNT);
      end
      for (int i = 0; i < 772; i++) begin
         SYNC_n = (i < 768 && i % 3 == 0) ? 1'b0 : 1'b1;
         tick();
         if (ERR_PULSE === 1'b1) pulses++;
         if (STATE !== 3'd5) bad++;
      end
      n_checks++;
      if (pulses != 256 || bad != 0) begin
         n_fail++; $display("FAIL sat_reports: pulses %0d off-DATA %0d want 256/0", pulses, bad);
      end
      n_checks++;
      if (ERR_CNT !== 8'd255) begin n_fail++; $display("FAIL err_saturate: got %0d want 255", ERR_CNT); end
      $display("test_err_saturate: reports=%0d err_cnt=%0d", pulses, ERR_CNT);
   endtask

   task automatic test_clr_with_err();
      logic p = 1'b0;
      logic [7:0] c = 8'hAA;
      for (int i = 0; i < 6; i++) begin
         SYNC_n  = (i == 0) ? 1'b0 : 1'b1;
         CLR_CNT = (i == 3);
         tick();
         if (i == 3) begin p = ERR_PULSE; c = ERR_CNT; end
      end
      CLR_CNT = 1'b0;
      n_checks++;
      if (p !== 1'b1 || c !== 8'd0) begin
         n_fail++; $display("FAIL clr_over_inc: pulse %b err %0d want 1/0", p, c);
      end
      for (int i = 0; i < 6; i++) begin
         SYNC_n = (i == 0) ? 1'b0 : 1'b1;
         tick();
      end
      n_checks++;
      if (ERR_CNT !== 8'd1) begin n_fail++; $display("FAIL err_after_clr: got %0d want 1", ERR_CNT); end
      $display("test_clr_with_err: err_cnt=%0d", ERR_CNT);
   endtask

   task automatic test_en_off_delay();
      SYNC_n = 1'b1; EN = 1'b0; ILA_DELAY = 8'd3;
      tick(3);
      EN = 1'b1;
      tick(2);
      LMFC_ME = 4'b0010;
      tick();
      LMFC_ME = 4'b0000;
      tick(2);
      n_checks++;
      if (STATE !== 3'd3) begin n_fail++; $display("FAIL delay_reached: got %0d want 3", STATE); end
      EN = 1'b0;
      tick();
      n_checks++;
      if (STATE !== 3'd0 || CGS_EN !== 1'b0) begin
         n_fail++; $display("FAIL en_off_delay: state %0d cgs_en %b want 0/0", STATE, CGS_EN);
      end
      n_checks++;
      if (ERR_CNT !== 8'd1) begin n_fail++; $display("FAIL en_off_hold: err %0d want 1", ERR_CNT); end
      $display("test_en_off_delay: state=%0d", STATE);
   endtask

   task automatic test_subclass1();
      int bad = 0;
      SUBCLASSV = 3'd1; LMFC_SYNCED = 1'b0; ILA_DELAY = 8'd0; EN = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         if (STATE !== 3'd1) bad++;
         tick();
      end
      n_checks++;
      if (bad != 0 || STATE !== 3'd1) begin
         n_fail++; $display("FAIL sc1_gate: %0d cycles outside CGS, state %0d want 0/1", bad, STATE);
      end
      LMFC_SYNCED = 1'b1;
      tick();
      n_checks++;
      if (STATE !== 3'd2) begin n_fail++; $display("FAIL sc1_release: got %0d want 2", STATE); end
      LMFC_SYNCED = 1'b0; SUBCLASSV = 3'd0;
      $display("test_subclass1: state=%0d", STATE);
   endtask

   task automatic test_reset_mid();
      goto_data();
      n_checks++;
      if (STATE !== 3'd5) begin n_fail++; $display("FAIL rst_pre_data: got %0d want 5", STATE); end
      #2;
      RST_n = 1'b0;
      #1;
      n_checks++;
      if (STATE !== 3'd0 || {CGS_EN, ILA_START, DATA_EN, ERR_PULSE} !== 4'b0000) begin
         n_fail++; $display("FAIL rst_async: state %0d strobes %b want 0/0000", STATE, {CGS_EN, ILA_START, DATA_EN, ERR_PULSE});
      end
      n_checks++;
      if (ERR_CNT !== 8'd0 || RESYNC_CNT !== 8'd0) begin
         n_fail++; $display("FAIL rst_counters: err %0d resync %0d want 0/0", ERR_CNT, RESYNC_CNT);
      end
      tick(2);
      RST_n = 1'b1;
      tick();
      n_checks++;
      if (STATE !== 3'd1) begin n_fail++; $display("FAIL rst_restart: got %0d want 1", STATE); end
      $display("test_reset_mid: state=%0d", STATE);
   endtask

   initial begin
      RST_n = 1'b0; EN = 1'b0; SUBCLASSV = 3'd0; LMFC_SYNCED = 1'b0; LMFC_ME = 4'b0000;
      ILA_DELAY = 8'd0; ILA_DONE = 1'b0; RESYNC_TH = 8'd20; CLR_CNT = 1'b0; SYNC_n = 1'b0;
      test_reset();
      test_subclass0();
      test_error_report();
      test_resync();
      test_ila_delay0();
      test_resync_th0();
      test_err_saturate();
      test_clr_with_err();
      test_en_off_delay();
      test_subclass1();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
